// File: rtl/enemy_formation_if.sv
`default_nettype none
// ============================================================================
// Module : enemy_formation_if
// Control/shot inputs and packed enemy-row outputs of the formation controller.
// Rev    : 1.0
// ============================================================================
interface enemy_formation_if #(
  parameter int N_ENEMIES = 5,
  parameter int COORD_W   = 10
);
  logic                           pausa;
  logic                           move_tick;
  logic                           shot_active;
  logic [COORD_W-1:0]             shot_x;
  logic [COORD_W-1:0]             shot_y;
  logic [N_ENEMIES*COORD_W-1:0]   inimigo_x;
  logic [N_ENEMIES*COORD_W-1:0]   inimigo_y;
  logic [N_ENEMIES-1:0]           inimigo_vivo_array;
  logic                           hit_pulse;
  logic [3:0]                     hit_index;
  logic                           all_dead;
  logic                           reached_bottom;
  logic [7:0]                     wave;

  modport master (
    output pausa, move_tick, shot_active, shot_x, shot_y,
    input  inimigo_x, inimigo_y, inimigo_vivo_array, hit_pulse, hit_index,
           all_dead, reached_bottom, wave
  );

  modport slave (
    input  pausa, move_tick, shot_active, shot_x, shot_y,
    output inimigo_x, inimigo_y, inimigo_vivo_array, hit_pulse, hit_index,
           all_dead, reached_bottom, wave
  );
endinterface
`default_nettype wire

// File: rtl/enemy_formation.sv
`default_nettype none
// ============================================================================
// Module : enemy_formation
// Marches a rigid row of enemies, kills the slot hit by the ball, restarts waves.
// Rev    : 1.0
// ============================================================================
module enemy_formation #(
  parameter int N_ENEMIES = 5,
  parameter int COORD_W   = 10,
  parameter int SPACING   = 80,
  parameter int ENEMY_W   = 40,
  parameter int ENEMY_H   = 30,
  parameter int STEP_X    = 8,
  parameter int STEP_Y    = 20,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 640,
  parameter int Y_LIMIT   = 440,
  parameter int X0        = 40,
  parameter int Y0        = 40
) (
  input  wire              CLOCK_50,
  input  wire              reset,
  enemy_formation_if.slave bus
);
  localparam int XW = COORD_W + 2;

  typedef enum logic [1:0] {
    S_MARCH_R = 2'd0,
    S_MARCH_L = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t                r_state, w_state_nx;
  logic signed [XW-1:0]  r_base_x, w_base_x_nx;
  logic [XW-1:0]         r_base_y, w_base_y_nx;
  logic [N_ENEMIES-1:0]  r_alive, w_alive_nx, w_alive_after;
  logic [7:0]            r_wave, w_wave_nx;
  logic                  r_hit_pulse, w_hit_pulse_nx;
  logic [3:0]            r_hit_index, w_hit_index_nx;
  logic                  r_bottom, w_bottom_nx;

  logic [COORD_W-1:0]    w_slot_x [N_ENEMIES];
  logic [COORD_W-1:0]    w_slot_y;
  logic [N_ENEMIES-1:0]  w_hit_vec;
  logic [N_ENEMIES-1:0]  w_hit_onehot;
  logic [3:0]            w_hit_idx;
  logic [COORD_W-1:0]    w_xl, w_xr;
  logic                  w_active;
  logic                  w_descend;

  always_comb begin
    for (int i = 0; i < N_ENEMIES; i++) begin
      w_slot_x[i] = COORD_W'(r_base_x + XW'(i * SPACING));
    end
    w_slot_y = COORD_W'(r_base_y);
  end

  // Hits use the positions held in the registers, i.e. before any march step this cycle.
  always_comb begin
    w_hit_vec = '0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      w_hit_vec[i] = bus.shot_active && r_alive[i]
                     && (int'(bus.shot_x) >= int'(w_slot_x[i]))
                     && (int'(bus.shot_x) <  int'(w_slot_x[i]) + ENEMY_W)
                     && (int'(bus.shot_y) >= int'(w_slot_y))
                     && (int'(bus.shot_y) <  int'(w_slot_y) + ENEMY_H);
    end
    w_hit_onehot = '0;
    w_hit_idx    = '0;
    for (int i = N_ENEMIES - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        w_hit_onehot    = '0;
        w_hit_onehot[i] = 1'b1;
        w_hit_idx       = 4'(i);
      end
    end
  end

  // Row edges come from the mask after this cycle's kill.
  always_comb begin
    w_active      = !bus.pausa && (r_state != S_HALT);
    w_alive_after = w_active ? (r_alive & ~w_hit_onehot) : r_alive;
    w_xl          = '0;
    w_xr          = '0;
    for (int i = N_ENEMIES - 1; i >= 0; i--) begin
      if (w_alive_after[i]) w_xl = w_slot_x[i];
    end
    for (int i = 0; i < N_ENEMIES; i++) begin
      if (w_alive_after[i]) w_xr = w_slot_x[i];
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_base_x_nx    = r_base_x;
    w_base_y_nx    = r_base_y;
    w_alive_nx     = r_alive;
    w_wave_nx      = r_wave;
    w_hit_pulse_nx = 1'b0;
    w_hit_index_nx = r_hit_index;
    w_bottom_nx    = r_bottom;
    w_descend      = 1'b0;
    if (w_active) begin
      w_alive_nx = w_alive_after;
      if (|w_hit_vec) begin
        w_hit_pulse_nx = 1'b1;
        w_hit_index_nx = w_hit_idx;
      end
      if (bus.move_tick) begin
        if (r_alive == '0) begin
          w_state_nx  = S_MARCH_R;
          w_base_x_nx = XW'(X0);
          w_base_y_nx = XW'(Y0);
          w_alive_nx  = '1;
          w_wave_nx   = (r_wave == 8'hFF) ? r_wave : r_wave + 8'd1;
        end else if (w_alive_after != '0) begin
          if (r_state == S_MARCH_R) begin
            if (int'(w_xr) + ENEMY_W + STEP_X > X_MAX) w_descend = 1'b1;
            else w_base_x_nx = r_base_x + XW'(STEP_X);
          end else begin
            if (int'(w_xl) < X_MIN + STEP_X) w_descend = 1'b1;
            else w_base_x_nx = r_base_x - XW'(STEP_X);
          end
          if (w_descend) begin
            w_base_y_nx = r_base_y + XW'(STEP_Y);
            if (int'(w_base_y_nx) + ENEMY_H >= Y_LIMIT) begin
              w_bottom_nx = 1'b1;
              w_state_nx  = S_HALT;
            end else begin
              w_state_nx = (r_state == S_MARCH_R) ? S_MARCH_L : S_MARCH_R;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= S_MARCH_R;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_base_x    <= XW'(X0);
      r_base_y    <= XW'(Y0);
      r_alive     <= '1;
      r_wave      <= '0;
      r_hit_pulse <= 1'b0;
      r_hit_index <= '0;
      r_bottom    <= 1'b0;
    end else begin
      r_base_x    <= w_base_x_nx;
      r_base_y    <= w_base_y_nx;
      r_alive     <= w_alive_nx;
      r_wave      <= w_wave_nx;
      r_hit_pulse <= w_hit_pulse_nx;
      r_hit_index <= w_hit_index_nx;
      r_bottom    <= w_bottom_nx;
    end
  end

  generate
    for (genvar g = 0; g < N_ENEMIES; g++) begin : g_slot_out
      assign bus.inimigo_x[g*COORD_W +: COORD_W] = r_alive[g] ? w_slot_x[g] : '0;
      assign bus.inimigo_y[g*COORD_W +: COORD_W] = r_alive[g] ? w_slot_y    : '0;
    end
  endgenerate

  assign bus.inimigo_vivo_array = r_alive;
  assign bus.hit_pulse          = r_hit_pulse;
  assign bus.hit_index          = r_hit_index;
  assign bus.all_dead           = (r_alive == '0);
  assign bus.reached_bottom     = r_bottom;
  assign bus.wave               = r_wave;

endmodule
`default_nettype wire
